pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
// Central stall/flush sequencer for the 5-stage pipeline (IF, ID, EX, MEM, WB).
// Detects load-use hazards and taken-branch flushes, and runs the data-memory req/ack handshake.
// Drives the PC, IF_ID and ID_EX write/flush/bubble controls and a global pipe-enable.
// Also provides a saturating stall counter and a sticky memory-timeout error.
// PARAMETERS
// REG_AW     5    register address width
// TIMEOUT    64   max MEM_WAIT cycles before error (>=2)
// CNT_W      16   stall counter width
// PORTS
// clk_i          in   1       clock, rising edge
// rst_i          in   1       reset, asynchronous, active-low
// start_i        in   1       pipeline run enable
// ifid_rs1_i     in   REG_AW  rs1 of instruction in ID
// ifid_rs2_i     in   REG_AW  rs2 of instruction in ID
// idex_memread_i in   1       ID_EX MemRead
// idex_rd_i      in   REG_AW  ID_EX RDaddr
// branch_taken_i in   1       branch resolved taken in ID
// exmem_memrd_i  in   1       EX_MEM MemRead
// exmem_memwr_i  in   1       EX_MEM MemWrite
// dmem_ack_i     in   1       data memory completes access this cycle
// dmem_req_o     out  1       data memory request
// pipe_en_o      out  1       global stage-register enable (0 = freeze all)
// pc_write_o     out  1       PC update enable
// ifid_write_o   out  1       IF_ID write enable
// ifid_flush_o   out  1       IF_ID flush (insert NOP)
// idex_bubble_o  out  1       zero ID_EX control fields
// stall_cnt_o    out  CNT_W   stall cycles since reset, saturating
// err_o          out  1       sticky memory-timeout error
// BEHAVIOUR
// - Reset (rst_i=0, async): state=IDLE, wait_cnt=0, stall_cnt_o=0, err_o=0.
//   Combinational outputs then evaluate to IDLE values: all 0.
// - FSM states: IDLE, RUN, MEM_WAIT, ERROR. State updates on the clk_i rising edge.
// - IDLE: all outputs 0. start_i=1 -> RUN.
// - RUN:
//   - mem = exmem_memrd_i|exmem_memwr_i; dmem_req_o=mem.
//   - If mem & !dmem_ack_i -> MEM_WAIT; pipe_en_o=pc_write_o=ifid_write_o=0 this cycle.
//   - mem & ack in the same cycle -> zero-wait access, no stall.
//   - Otherwise pipe_en_o=1 and hazard logic applies.
//   - If start_i=0 and no pending mem -> IDLE.
// - MEM_WAIT:
//   - dmem_req_o=1; pipe_en_o=pc_write_o=ifid_write_o=0; wait_cnt increments each cycle.
//   - The ack cycle releases the pipe: pipe_en_o=1, hazard logic applies, wait_cnt clears.
//     Next state is RUN, or IDLE if start_i=0.
//   - start_i=0 while waiting: the access still completes before IDLE.
//   - wait_cnt==TIMEOUT-1 without ack -> ERROR.
// - ERROR: err_o=1; dmem_req_o=0; all enables 0. Exit only by reset.
// - Load-use, when pipe_en_o=1:
//   - Hazard = idex_memread_i & idex_rd_i!=0 & (idex_rd_i==ifid_rs1_i | idex_rd_i==ifid_rs2_i).
//   - Response: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1. Exactly 1 cycle per hazard.
// - Branch flush: when pipe_en_o=1 and branch_taken_i and no load-use, ifid_flush_o=1.
//   pc_write_o stays 1.
// - Priority: memory freeze > load-use stall > branch flush.
//   A flush is never asserted in a freeze or load-use cycle.
// - Defaults when pipe_en_o=1 and no hazard: pc_write_o=ifid_write_o=1; flush=bubble=0.
// - stall_cnt_o: +1 on every cycle where state is RUN/MEM_WAIT and pc_write_o=0.
//   Saturates at 2^CNT_W-1.
// - All outputs except stall_cnt_o and err_o are combinational from state and inputs.
//   There is zero added latency.
// STRUCTURE
// - hazard_pkg: state enum {IDLE,RUN,MEM_WAIT,ERROR} and the REG_AW default.
// - Sub-module load_use_detect: combinational rd/rs compare; output hazard_o.
// - Top level: FSM, wait/stall counters, priority muxing.
// TESTING
// - Reset then start_i=1, no mem, no hazards -> state RUN at cycle 1.
//   pc_write_o=ifid_write_o=pipe_en_o=1; stall_cnt_o stays 0.
// - idex_memread_i=1, idex_rd_i=5, ifid_rs2_i=5 -> one cycle pc_write_o=0, idex_bubble_o=1.
//   stall_cnt_o=1. With idex_rd_i=0 -> no stall.
// - exmem_memrd_i=1, ack 3 cycles later -> dmem_req_o=1 for 4 cycles; pipe_en_o=0 for 3 cycles.
//   pipe_en_o=1 on the ack cycle; stall_cnt_o=3.
// - branch_taken_i=1 together with a load-use hazard -> ifid_flush_o=0, bubble=1.
//   On the next cycle, with the branch still taken, ifid_flush_o=1.
// - TIMEOUT=4, no ack -> err_o=1 after 4 wait cycles. Outputs stay 0 until rst_i=0.
//   After reset: err_o=0, state IDLE.
// - rst_i=0 mid-MEM_WAIT -> outputs 0 immediately (async); counters 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and defaults for the pipeline hazard controller
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Default register-file address width (32 architectural registers)
    localparam int REG_AW_DEFAULT = 5;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Flags an instruction in ID that reads the destination of a
//               load currently in EX (register 0 never creates a hazard)
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic [REG_AW-1:0] ifid_rs1_i,
    input  logic [REG_AW-1:0] ifid_rs2_i,
    output logic              hazard_o
);

    // Compare the load destination against both ID source operands
    always_comb begin
        hazard_o = idex_memread_i
                && (idex_rd_i != '0)
                && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush sequencer for a 5-stage pipeline: memory freeze,
//               load-use stall, taken-branch flush, stall counter and a sticky
//               data-memory timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW  = REG_AW_DEFAULT,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [REG_AW-1:0] ifid_rs1_i,
    input  logic [REG_AW-1:0] ifid_rs2_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              branch_taken_i,
    input  logic              exmem_memrd_i,
    input  logic              exmem_memwr_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              pipe_en_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              err_o
);

    // Wait counter only needs to reach TIMEOUT-1
    localparam int               c_wait_w    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_stall_max = '1;

    state_e               state_q,     state_d;
    logic [c_wait_w-1:0]  wait_cnt_q,  wait_cnt_d;
    logic [CNT_W-1:0]     stall_cnt_q, stall_cnt_d;
    logic                 err_q,       err_d;

    logic w_load_use;
    logic w_mem;
    logic w_release;

    load_use_detect #(
        .REG_AW (REG_AW)
    ) u_load_use_detect (
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .hazard_o       (w_load_use)
    );

    assign w_mem = exmem_memrd_i | exmem_memwr_i;

    // Next state, counters and prioritised pipeline controls (freeze > load-use > flush)
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        stall_cnt_d   = stall_cnt_q;
        err_d         = err_q;
        w_release     = 1'b0;
        dmem_req_o    = 1'b0;
        pipe_en_o     = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                dmem_req_o = w_mem;
                if (w_mem && !dmem_ack_i) begin
                    // Access not completed this cycle: freeze and wait for ack
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = '0;
                end else begin
                    w_release = 1'b1;
                    if (!start_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_MEM_WAIT: begin
                dmem_req_o = 1'b1;
                if (dmem_ack_i) begin
                    // Ack cycle releases the pipe; a dropped start takes effect now
                    w_release  = 1'b1;
                    wait_cnt_d = '0;
                    state_d    = start_i ? ST_RUN : ST_IDLE;
                end else if (wait_cnt_q == c_wait_last) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (w_release) begin
            pipe_en_o = 1'b1;
            if (w_load_use) begin
                idex_bubble_o = 1'b1;
            end else begin
                pc_write_o   = 1'b1;
                ifid_write_o = 1'b1;
                ifid_flush_o = branch_taken_i;
            end
        end

        // Any active cycle where the PC is held counts as a stall
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_write_o
            && (stall_cnt_q != c_stall_max)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State and counter registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            err_q       <= err_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign err_o       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl with directed
//               scenarios and randomized traffic against a behavioural model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    localparam int AW      = 5;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic          start_i = 1'b0;
    logic [AW-1:0] ifid_rs1_i = '0;
    logic [AW-1:0] ifid_rs2_i = '0;
    logic          idex_memread_i = 1'b0;
    logic [AW-1:0] idex_rd_i = '0;
    logic          branch_taken_i = 1'b0;
    logic          exmem_memrd_i = 1'b0;
    logic          exmem_memwr_i = 1'b0;
    logic          dmem_ack_i = 1'b0;
    logic          dmem_req_o, pipe_en_o, pc_write_o, ifid_write_o;
    logic          ifid_flush_o, idex_bubble_o, err_o;
    logic [CNT_W-1:0] stall_cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    // Behavioural model: running / waiting / errored flags plus counts
    bit  m_run, m_wait, m_err, m_frozen, m_pcw;
    int  m_waits, m_stall;
    logic [6+CNT_W:0] exp_vec;

    pipeline_hazard_ctrl #(
        .REG_AW  (AW),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .start_i        (start_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .branch_taken_i (branch_taken_i),
        .exmem_memrd_i  (exmem_memrd_i),
        .exmem_memwr_i  (exmem_memwr_i),
        .dmem_ack_i     (dmem_ack_i),
        .dmem_req_o     (dmem_req_o),
        .pipe_en_o      (pipe_en_o),
        .pc_write_o     (pc_write_o),
        .ifid_write_o   (ifid_write_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .stall_cnt_o    (stall_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [6+CNT_W:0] dut_vec();
        return {dmem_req_o, pipe_en_o, pc_write_o, ifid_write_o,
                ifid_flush_o, idex_bubble_o, err_o, stall_cnt_o};
    endfunction

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_err = 0; m_waits = 0; m_stall = 0;
    endtask

    // Expected outputs from the current model state and inputs
    task automatic model_eval();
        logic mem, hz, pipe, req;
        mem      = exmem_memrd_i | exmem_memwr_i;
        hz       = idex_memread_i && (idex_rd_i != 0)
                && ((idex_rd_i == ifid_rs1_i) || (idex_rd_i == ifid_rs2_i));
        m_frozen = m_wait ? !dmem_ack_i : (mem && !dmem_ack_i);
        req      = m_wait || mem;
        pipe     = !m_frozen;
        m_pcw    = pipe && !hz;
        exp_vec  = {6'b0, m_err, CNT_W'(m_stall)};
        if (!m_err && m_run)
            exp_vec[6+CNT_W:7+CNT_W-6] = {req, pipe, m_pcw, m_pcw,
                                          pipe && !hz && branch_taken_i, pipe && hz};
    endtask

    // Model update at a rising edge
    task automatic model_clock();
        if (m_err) begin
        end else if (!m_run) begin
            m_run = start_i;
        end else begin
            if (!m_pcw && m_stall < SAT) m_stall++;
            if (m_frozen) begin
                if (m_wait) begin
                    m_waits++;
                    if (m_waits == TIMEOUT) begin
                        m_err  = 1;
                        m_wait = 0;
                    end
                end else begin
                    m_wait  = 1;
                    m_waits = 0;
                end
            end else begin
                m_wait = 0;
                if (!start_i) m_run = 0;
            end
        end
    endtask

    task automatic adv();
        @(posedge clk_i);
        model_clock();
        @(negedge clk_i);
    endtask

    task automatic set_in(input logic s, input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                          input logic mr, input logic [AW-1:0] rd, input logic br,
                          input logic mrd, input logic mwr, input logic ack);
        start_i = s; ifid_rs1_i = r1; ifid_rs2_i = r2; idex_memread_i = mr;
        idex_rd_i = rd; branch_taken_i = br; exmem_memrd_i = mrd;
        exmem_memwr_i = mwr; dmem_ack_i = ack;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got %b want %b", dut_vec(), {(7+CNT_W){1'b0}});
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_in(i != 0, 0, 0, 0, 0, 0, 0, 0, 0);
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec) begin
                n_bad++;
                $display("FAIL start_run c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        set_in(1, 5'd1, 5'd5, 1, 5'd5, 0, 0, 0, 0);
        #1; model_eval(); n_vec++;
        if (dut_vec() !== exp_vec || {pc_write_o, ifid_write_o, idex_bubble_o} !== 3'b001) begin
            n_bad++;
            $display("FAIL load_use_stall: got %b want %b", dut_vec(), exp_vec);
        end
        adv();
        set_in(1, 5'd0, 5'd0, 1, 5'd0, 0, 0, 0, 0);
        #1; model_eval(); n_vec++;
        if (dut_vec() !== exp_vec || stall_cnt_o !== 4'd1 || pc_write_o !== 1'b1) begin
            n_bad++;
            $display("FAIL load_use_rd0: got %b want %b cnt 1", dut_vec(), exp_vec);
        end
        adv();
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        for (int i = 0; i < 4; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 0, i == 3);
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec || dmem_req_o !== 1'b1 || pipe_en_o !== (i == 3)) begin
                n_bad++;
                $display("FAIL mem_wait c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1; n_vec++;
        if (stall_cnt_o !== 4'd3) begin
            n_bad++;
            $display("FAIL mem_wait_cnt: got %0d want 3", stall_cnt_o);
        end
        adv();
    endtask

    task automatic test_branch_priority();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        set_in(1, 5'd7, 5'd2, 1, 5'd7, 1, 0, 0, 0);
        #1; model_eval(); n_vec++;
        if (dut_vec() !== exp_vec || {ifid_flush_o, idex_bubble_o} !== 2'b01) begin
            n_bad++;
            $display("FAIL branch_vs_loaduse: got %b want %b", dut_vec(), exp_vec);
        end
        adv();
        set_in(1, 5'd7, 5'd2, 0, 5'd7, 1, 0, 0, 0);
        #1; model_eval(); n_vec++;
        if (dut_vec() !== exp_vec || {ifid_flush_o, pc_write_o} !== 2'b11) begin
            n_bad++;
            $display("FAIL branch_flush: got %b want %b", dut_vec(), exp_vec);
        end
        adv();
        // Branch during a memory freeze must not flush
        set_in(1, 0, 0, 0, 0, 1, 0, 1, 0);
        #1; model_eval(); n_vec++;
        if (dut_vec() !== exp_vec || ifid_flush_o !== 1'b0) begin
            n_bad++;
            $display("FAIL branch_in_freeze: got %b want %b", dut_vec(), exp_vec);
        end
        adv();
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        for (int i = 0; i < 5; i++) begin
            set_in(1, 0, 0, 0, 0, 0, 1, 0, 0);
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec) begin
                n_bad++;
                $display("FAIL timeout_wait c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
        for (int i = 0; i < 3; i++) begin
            set_in(1, 5'd3, 5'd3, 1, 5'd3, 1, 1, 1, 1);
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec || dut_vec() !== {6'b0, 1'b1, 4'd5}) begin
                n_bad++;
                $display("FAIL error_sticky c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
        do_reset();
        #1; n_vec++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL error_cleared: got %b want 0", dut_vec());
        end
        @(negedge clk_i);
    endtask

    task automatic test_async_reset();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        set_in(1, 5'd1, 5'd1, 1, 5'd1, 0, 0, 0, 0); #1; model_eval(); adv();
        set_in(1, 0, 0, 0, 0, 0, 1, 0, 0); #1; model_eval(); adv();
        #1; model_eval(); adv();
        #2;
        rst_i = 1'b0;
        #1; n_vec++;
        if (dut_vec() !== '0) begin
            n_bad++;
            $display("FAIL async_reset: got %b want 0", dut_vec());
        end
        model_reset();
        @(negedge clk_i);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0); #1; adv();
        // Zero-wait accesses, a load-use, then start dropped mid-wait
        for (int i = 0; i < 7; i++) begin
            case (i)
                0, 1:    set_in(1, 0, 0, 0, 0, 0, 0, 1, 1);
                2:       set_in(1, 5'd4, 5'd9, 1, 5'd4, 0, 1, 0, 1);
                3:       set_in(1, 0, 0, 0, 0, 0, 0, 1, 0);
                4:       set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
                5:       set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
                default: set_in(0, 0, 0, 0, 0, 1, 0, 0, 0);
            endcase
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec) begin
                n_bad++;
                $display("FAIL back_to_back c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 79) == 0) do_reset();
            set_in($urandom_range(0, 9) != 0,
                   AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 9) < 6);
            #1; model_eval(); n_vec++;
            if (dut_vec() !== exp_vec) begin
                n_bad++;
                $display("FAIL random c%0d: got %b want %b", i, dut_vec(), exp_vec);
            end
            adv();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_load_use();
        test_mem_wait();
        test_branch_priority();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
